mux_key_with_default: RTL and testbench



---
 rtl/mux_key_with_default.sv | 88 ++++++++
 tb/tb_mux_key_with_default.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mux_key_with_default.sv
// mux_key_with_default
// Key-lookup multiplexer with a default value. `key` is compared against every
// (key, data) pair of the packed table `lut`. The data of the matching pair is
// driven on `out`. If no pair matches, `default_out` is driven instead.
// Duplicate keys resolve to the lowest-index entry, which is the one listed
// first in the concatenation.
//
// Configuration macro: MUX_KEY_WITH_DEFAULT_REG_OUT_EN
//   undefined : `out`/`hit` are purely combinational; clk/rst_n are unused.
//   defined   : `out`/`hit` are registered on the rising edge of clk, with
//               asynchronous active-low clear to 0.
//
// Parameters:
//   NR_KEY   number of (key, data) pairs (>= 1)
//   KEY_LEN  key width (>= 1)
//   DATA_LEN data width (>= 1)
//
// Ports:
//   clk          clock (used only in registered mode)
//   rst_n        asynchronous active-low reset (used only in registered mode)
//   out          selected data, DATA_LEN bits
//   key          lookup key, KEY_LEN bits
//   default_out  value driven when no entry matches
//   lut          packed table, MSB-first: {k0, d0, k1, d1, ...}
//   hit          high when at least one entry matches
module mux_key_with_default #(
   parameter int unsigned NR_KEY   = 2,
   parameter int unsigned KEY_LEN  = 1,
   parameter int unsigned DATA_LEN = 1
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   output logic [DATA_LEN-1:0]                  out,
   input  logic [KEY_LEN-1:0]                   key,
   input  logic [DATA_LEN-1:0]                  default_out,
   input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut,
   output logic                                 hit
);

   localparam int unsigned PairLen = KEY_LEN + DATA_LEN;

   logic [KEY_LEN-1:0]  key_tab  [NR_KEY];
   logic [DATA_LEN-1:0] data_tab [NR_KEY];
   logic [NR_KEY-1:0]   match;
   logic [DATA_LEN-1:0] sel_out;
   logic                sel_hit;

   // Unpack the table. Entry 0 sits in the most significant slice.
   for (genvar i = 0; i < NR_KEY; i++) begin : g_entry
      localparam int unsigned Base = (NR_KEY - 1 - i) * PairLen;
      assign key_tab[i]  = lut[Base + DATA_LEN +: KEY_LEN];
      assign data_tab[i] = lut[Base +: DATA_LEN];
      assign match[i]    = (key_tab[i] == key);
   end

   // Scan from the highest index down, so the lowest matching index is
   // written last and therefore wins. This is a priority select, never an OR.
   always_comb begin
      sel_out = default_out;
      for (int i = int'(NR_KEY) - 1; i >= 0; i--) begin
         if (match[i]) begin
            sel_out = data_tab[i];
         end
      end
   end

   assign sel_hit = |match;

`ifdef MUX_KEY_WITH_DEFAULT_REG_OUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out <= '0;
         hit <= 1'b0;
      end else begin
         out <= sel_out;
         hit <= sel_hit;
      end
   end
`else
   assign out = sel_out;
   assign hit = sel_hit;

   // Clock and reset have no function in combinational mode.
   logic unused_clk_rst;
   assign unused_clk_rst = clk ^ rst_n;
`endif

endmodule

// File: tb/tb_mux_key_with_default.sv
module tb_mux_key_with_default;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // DUT 0: GPR read-port gating table
   logic [31:0] g_out, g_def;
   logic        g_key, g_hit;
   logic [65:0] g_lut;
   // DUT 1: four-entry table, 3-bit keys
   logic [31:0]  t_out, t_def;
   logic [2:0]   t_key;
   logic         t_hit;
   logic [139:0] t_lut;
   // DUT 2: duplicate-key table
   logic [7:0]  d_out, d_def;
   logic [1:0]  d_key;
   logic        d_hit;
   logic [19:0] d_lut;
   // DUT 3: full 3-bit key sweep
   logic [7:0]  s_out, s_def;
   logic [2:0]  s_key;
   logic        s_hit;
   logic [87:0] s_lut;

   mux_key_with_default #(.NR_KEY(2), .KEY_LEN(1), .DATA_LEN(32)) u_gpr (
      .clk(clk), .rst_n(rst_n), .out(g_out), .key(g_key),
      .default_out(g_def), .lut(g_lut), .hit(g_hit));
   mux_key_with_default #(.NR_KEY(4), .KEY_LEN(3), .DATA_LEN(32)) u_tab4 (
      .clk(clk), .rst_n(rst_n), .out(t_out), .key(t_key),
      .default_out(t_def), .lut(t_lut), .hit(t_hit));
   mux_key_with_default #(.NR_KEY(2), .KEY_LEN(2), .DATA_LEN(8)) u_dup (
      .clk(clk), .rst_n(rst_n), .out(d_out), .key(d_key),
      .default_out(d_def), .lut(d_lut), .hit(d_hit));
   mux_key_with_default #(.NR_KEY(8), .KEY_LEN(3), .DATA_LEN(8)) u_sweep (
      .clk(clk), .rst_n(rst_n), .out(s_out), .key(s_key),
      .default_out(s_def), .lut(s_lut), .hit(s_hit));

   typedef struct {
      int          id;
      logic [31:0] exp_out;
      logic        exp_hit;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   req_cnt = 0;
   int   ack_cnt = 0;
   int   tests = 0;
   int   fails = 0;

   // Monitor: on every falling edge with an outstanding request, pop and compare.
   always @(negedge clk) begin
      if (ack_cnt != req_cnt) begin
         exp_t        e;
         logic [31:0] got_out;
         logic        got_hit;
         ack_cnt = ack_cnt + 1;
         tests = tests + 1;
         if (sb.size() == 0) begin
            fails = fails + 1;
            $display("FAIL scoreboard_empty: output presented but no expected value queued");
         end else begin
            e = sb.pop_front();
            case (e.id)
               0:       begin got_out = g_out;          got_hit = g_hit; end
               1:       begin got_out = t_out;          got_hit = t_hit; end
               2:       begin got_out = {24'h0, d_out}; got_hit = d_hit; end
               default: begin got_out = {24'h0, s_out}; got_hit = s_hit; end
            endcase
            if (got_out !== e.exp_out || got_hit !== e.exp_hit) begin
               fails = fails + 1;
               $display("FAIL %s: got out=%h hit=%b, expected out=%h hit=%b",
                        e.name, got_out, got_hit, e.exp_out, e.exp_hit);
            end
         end
      end
   end

   // Queue an expectation and request one monitor sample. `no_lat` skips the
   // register latency, for checks of the asynchronous reset.
   task automatic issue(input int id, input logic [31:0] eo, input logic eh,
                        input string name, input bit no_lat);
      sb.push_back('{id: id, exp_out: eo, exp_hit: eh, name: name});
`ifdef MUX_KEY_WITH_DEFAULT_REG_OUT_EN
      if (!no_lat) begin
         @(posedge clk);
         #1;
      end
`endif
      req_cnt = req_cnt + 1;
      @(negedge clk);
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [2:0] k3;
   logic [7:0] d8;

   initial begin
      g_lut = {1'b0, 32'h0, 1'b1, 32'hDEADBEEF};
      g_def = 32'h0;
      g_key = 1'b1;
      t_lut = {3'd3, 32'hAAAA0001, 3'd5, 32'hBBBB0002, 3'd6, 32'hCCCC0003, 3'd7, 32'hDDDD0004};
      t_def = 32'h12345678;
      t_key = 3'd0;
      d_lut = {2'b01, 8'hAA, 2'b01, 8'h55};
      d_def = 8'hC3;
      d_key = 2'b01;
      for (int i = 0; i < 8; i++) begin
         k3 = 3'(7 - i);
         d8 = 8'h30 + 8'(i);
         s_lut[(7 - i) * 11 +: 11] = {k3, d8};
      end
      s_def = 8'hEE;
      s_key = 3'd0;

      // Reset held low: registered outputs are cleared, combinational ones ignore it.
      step();
`ifdef MUX_KEY_WITH_DEFAULT_REG_OUT_EN
      issue(0, 32'h0, 1'b0, "reset_hold_gpr", 1'b1);
      issue(1, 32'h0, 1'b0, "reset_hold_tab4", 1'b1);
`else
      issue(0, 32'hDEADBEEF, 1'b1, "reset_hold_gpr", 1'b1);
      issue(1, 32'h12345678, 1'b0, "reset_hold_tab4", 1'b1);
`endif
      step();
      rst_n = 1'b1;

      step(); g_key = 1'b1; issue(0, 32'hDEADBEEF, 1'b1, "gpr_key1", 1'b0);
      step(); g_key = 1'b0; issue(0, 32'h0, 1'b1, "gpr_key0", 1'b0);

      step(); t_key = 3'd5; issue(1, 32'hBBBB0002, 1'b1, "tab4_key5", 1'b0);
      step(); t_key = 3'd2; issue(1, 32'h12345678, 1'b0, "tab4_key2_default", 1'b0);
      step(); t_key = 3'd3; issue(1, 32'hAAAA0001, 1'b1, "tab4_key3_first", 1'b0);
      step(); t_key = 3'd7; issue(1, 32'hDDDD0004, 1'b1, "tab4_key7_last", 1'b0);
      step(); t_def = 32'h0; t_key = 3'd0;
      issue(1, 32'h0, 1'b0, "tab4_key0_zero_default", 1'b0);

      step(); d_key = 2'b01; issue(2, 32'hAA, 1'b1, "dup_first_wins", 1'b0);
      step(); d_key = 2'b10; issue(2, 32'hC3, 1'b0, "dup_no_match", 1'b0);
      step(); d_lut = {2'b11, 8'h0F, 2'b11, 8'hF0}; d_key = 2'b11;
      issue(2, 32'h0F, 1'b1, "dup_not_or", 1'b0);

      // Sweep: entry i holds key 7-i and data 8'h30+i, so key k yields 8'h37-k.
      for (int k = 0; k < 8; k++) begin
         step();
         s_key = 3'(k);
         issue(3, {24'h0, 8'h37 - 8'(k)}, 1'b1, $sformatf("sweep_key%0d", k), 1'b0);
      end

      // Mid-stream reset, asserted between edges.
      step(); g_key = 1'b1; issue(0, 32'hDEADBEEF, 1'b1, "gpr_before_reset", 1'b0);
      step(); g_key = 1'b0; rst_n = 1'b0;
`ifdef MUX_KEY_WITH_DEFAULT_REG_OUT_EN
      issue(0, 32'h0, 1'b0, "gpr_mid_reset_clear", 1'b1);
`else
      issue(0, 32'h0, 1'b1, "gpr_mid_reset_clear", 1'b1);
`endif
      step(); rst_n = 1'b1; g_key = 1'b1;
      issue(0, 32'hDEADBEEF, 1'b1, "gpr_after_reset", 1'b0);

      // Drain: wait (bounded) for the monitor to consume everything.
      for (int n = 0; n < 20 && (ack_cnt != req_cnt || sb.size() != 0); n++) begin
         @(negedge clk);
         #1;
      end
      if (ack_cnt != req_cnt || sb.size() != 0) begin
         tests = tests + 1;
         fails = fails + 1;
         $display("FAIL drain: %0d expected values left unchecked, expected 0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
